// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - MIPS instruction fetch unit with delay-slot redirect handling
//
// Owns the architectural fetch PC, issues instruction-memory reads and buffers
// one fetched instruction for decode.
//
// Ports:
//   clk, reset          clock (rising edge) and synchronous active-low reset
//   redirect_valid/pc   taken branch/jump target for the instruction in decode
//   imem_req/addr       read request, held with a stable address until imem_ack
//   imem_ack/rdata      read completion and instruction word
//   out_valid/ready     handshake towards decode
//   out_instr/pc/pc4    instruction, its address and address+4
//   out_exc             misaligned-target address error
//
// Optional feature: define IFU_ALIGN_CHECK_EN to turn misaligned redirect
// targets into an address-error entry instead of silently aligning them.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        out_exc
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WAIT_SQ} state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_pc, last_pc, pend_pc, req_addr;
    logic [31:0] tgt, ds, cur_addr;
    logic        pend;
    logic        slot_free, fetch_ok, issue, xfer;
    logic        ds_in_out, ds_in_flight, load;

`ifdef IFU_ALIGN_CHECK_EN
    logic halt, exc_load, exc_r;
    assign tgt      = redirect_pc;
    assign fetch_ok = !halt && (fetch_pc[1:0] == 2'b00);
    // A misaligned target is never sent to memory; it becomes an error entry
    // once the output register can take it, and fetching stops afterwards.
    assign exc_load = reset && (state == S_IDLE) && !halt
                      && (fetch_pc[1:0] != 2'b00) && slot_free;
    assign out_exc  = exc_r;
`else
    assign tgt      = {redirect_pc[31:2], 2'b00};
    assign fetch_ok = 1'b1;
    assign out_exc  = 1'b0;
`endif

    assign slot_free = !out_valid || out_ready;
    assign xfer      = out_valid && out_ready;
    assign issue     = reset && (state == S_IDLE) && slot_free && fetch_ok;
    assign cur_addr  = (state == S_IDLE) ? fetch_pc : req_addr;
    assign imem_addr = cur_addr;

    // The redirect belongs to the last instruction handed to decode, so its
    // delay slot is the sequentially next address.
    assign ds           = last_pc + 32'd4;
    assign ds_in_out    = out_valid && (out_pc == ds);
    assign ds_in_flight = ((state == S_WAIT) || issue) && (cur_addr == ds);

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    imem_req = 1'b1;
                    if (imem_ack) load = 1'b1;
                    else          state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                imem_req = reset;
                if (imem_ack) begin
                    load     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_WAIT_SQ: begin
                imem_req = reset;
                if (imem_ack) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Delay slot already buffered: whatever is being fetched now is past
        // the branch and must not reach decode.
        if (redirect_valid && ds_in_out && imem_req) begin
            load     = 1'b0;
            state_nx = imem_ack ? S_IDLE : S_WAIT_SQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            last_pc   <= RESET_PC - 32'd4;
            pend      <= 1'b0;
            pend_pc   <= RESET_PC;
            req_addr  <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_pc    <= RESET_PC;
            out_pc4   <= RESET_PC + 32'd4;
`ifdef IFU_ALIGN_CHECK_EN
            halt      <= 1'b0;
            exc_r     <= 1'b0;
`endif
        end else begin
            state <= state_nx;

            if (xfer) begin
                out_valid <= 1'b0;
                last_pc   <= out_pc;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_instr <= imem_rdata;
                out_pc    <= cur_addr;
                out_pc4   <= cur_addr + 32'd4;
`ifdef IFU_ALIGN_CHECK_EN
                exc_r     <= 1'b0;
`endif
            end
`ifdef IFU_ALIGN_CHECK_EN
            if (exc_load) begin
                out_valid <= 1'b1;
                out_instr <= 32'd0;
                out_pc    <= fetch_pc;
                out_pc4   <= fetch_pc + 32'd4;
                exc_r     <= 1'b1;
                halt      <= 1'b1;
            end
`endif

            if (issue) begin
                req_addr <= fetch_pc;
                fetch_pc <= pend ? pend_pc : fetch_pc + 32'd4;
                pend     <= 1'b0;
            end

            if (redirect_valid) begin
`ifdef IFU_ALIGN_CHECK_EN
                if (halt) begin
                    fetch_pc <= tgt;
                    halt     <= 1'b0;
                    pend     <= 1'b0;
                end else
`endif
                if (ds_in_out || ds_in_flight) begin
                    fetch_pc <= tgt;
                    pend     <= 1'b0;
                end else begin
                    // Delay slot not requested yet: fetch it first, then jump.
                    pend    <= 1'b1;
                    pend_pc <= tgt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_exc;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .out_exc        (out_exc)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_xfer = 0;

    // Program-order model: the next address decode must see.
    logic [31:0] exp_pc;
    bit          ds_pending, ds_bad, exp_exc, halted_m;
    logic [31:0] ds_tgt;
    bit          redir_next;
    logic [31:0] redir_pc_next;

    // Memory and handshake tracking.
    int          wait_left, min_wait, max_wait, rdy_pct;
    bit          hold_prev, stall_prev;
    logic [31:0] hold_addr, stall_pc, stall_instr;

    // Directed-branch controls and observation captures.
    bit          force_en, rand_br, seen;
    logic [31:0] force_pc, force_tgt, watch_pc;
    logic        cap_req, cap_ov;
    logic [31:0] cap_addr, cap_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ (a << 3) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
        else t = 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
`ifndef IFU_ALIGN_CHECK_EN
        if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
`endif
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock cycle; entered and left at a falling edge.
    task automatic cycle();
        logic [31:0] x, t;
        bit br;
        if (hold_prev) begin
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_stable", imem_addr, hold_addr);
        end
        if (stall_prev) begin
            check("valid_held", 32'(out_valid), 32'd1);
            check("pc_stable", out_pc, stall_pc);
            check("instr_stable", out_instr, stall_instr);
        end
        redirect_valid = redir_next;
        redirect_pc    = redir_pc_next;
        redir_next     = 1'b0;
        out_ready      = ($urandom_range(0, 99) < rdy_pct);
        #1;
        cap_req = imem_req; cap_addr = imem_addr; cap_ov = out_valid; cap_pc = out_pc;
        if (halted_m) check("halted_no_req", 32'(imem_req), 32'd0);

        if (out_valid && out_ready) begin
            n_xfer++;
            x = exp_pc;
            check("out_pc", out_pc, x);
            check("out_pc4", out_pc4, x + 32'd4);
            if (x == watch_pc) seen = 1'b1;
            if (exp_exc) begin
                check("exc_flag", 32'(out_exc), 32'd1);
                check("exc_instr", out_instr, 32'd0);
                exp_exc  = 1'b0;
                halted_m = 1'b1;
            end else begin
                check("out_instr", out_instr, mem_word(x));
                check("out_exc", 32'(out_exc), 32'd0);
                if (ds_pending) begin
                    ds_pending = 1'b0;
                    exp_pc  = ds_tgt;
                    exp_exc = ds_bad;
                end else begin
                    exp_pc = x + 32'd4;
                    br = 1'b0;
                    if (force_en && x == force_pc) begin
                        t = force_tgt; force_en = 1'b0; br = 1'b1;
                    end else if (rand_br && $urandom_range(0, 4) == 0) begin
                        t = rand_tgt(); br = 1'b1;
                    end
                    if (br) begin
                        redir_next    = 1'b1;
                        redir_pc_next = t;
                        ds_pending    = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
                        ds_tgt = t;
                        ds_bad = (t[1:0] != 2'b00);
`else
                        ds_tgt = {t[31:2], 2'b00};
                        ds_bad = 1'b0;
`endif
                    end
                end
            end
        end
        stall_prev  = out_valid && !out_ready;
        stall_pc    = out_pc;
        stall_instr = out_instr;

        if (imem_req) begin
            if (!hold_prev) wait_left = $urandom_range(min_wait, max_wait);
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                wait_left--;
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
        end else begin
            imem_ack   = ($urandom_range(0, 9) == 0);
            imem_rdata = $urandom;
        end
        hold_prev = imem_req && !imem_ack;
        hold_addr = imem_addr;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit late_ack);
        reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        imem_ack = late_ack; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, RST_PC);
        check("rst_pc4", out_pc4, RST_PC + 32'd4);
        check("rst_exc", 32'(out_exc), 32'd0);
        imem_ack = 1'b0; reset = 1'b1;
        exp_pc = RST_PC; ds_pending = 1'b0; ds_bad = 1'b0; exp_exc = 1'b0;
        halted_m = 1'b0; redir_next = 1'b0; hold_prev = 1'b0; stall_prev = 1'b0;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RST_PC);
    endtask

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0; out_ready = 1'b0;
        rdy_pct = 100; min_wait = 0; max_wait = 0; rand_br = 1'b0;
        force_en = 1'b0; seen = 1'b0; watch_pc = 32'hFFFF_FFFF;
        @(negedge clk);

        // Zero-wait streaming, then branch at 0x3008 with the delay slot buffered.
        do_reset(1'b0);
        force_en = 1'b1; force_pc = 32'h3008; force_tgt = 32'h3100;
        watch_pc = 32'h3100; seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("zw_req", 32'(cap_req), 32'd1);
            check("zw_addr", cap_addr, RST_PC + 32'(4 * i));
            if (i > 0) begin
                check("zw_valid", 32'(cap_ov), 32'd1);
                check("zw_pc", cap_pc, RST_PC + 32'(4 * (i - 1)));
            end
        end
        repeat (6) cycle();
        check("squash_reached_tgt", 32'(seen), 32'd1);

        // Slow memory with stalls, branch at 0x300C to 0x3200.
        do_reset(1'b0);
        rdy_pct = 50; max_wait = 2;
        force_en = 1'b1; force_pc = 32'h300C; force_tgt = 32'h3200;
        watch_pc = 32'h3200; seen = 1'b0;
        repeat (60) cycle();
        check("late_redirect_reached_tgt", 32'(seen), 32'd1);

        // Randomised traffic with random branches.
        do_reset(1'b0);
        rand_br = 1'b1; rdy_pct = 70; max_wait = 2; n_xfer = 0;
        repeat (1500) cycle();
        check("random_progress", 32'(n_xfer > 200), 32'd1);
        rand_br = 1'b0;

        // Misaligned redirect target 0x3102.
        do_reset(1'b0);
        rdy_pct = 100; max_wait = 0;
        force_en = 1'b1; force_pc = 32'h3004; force_tgt = 32'h3102;
        watch_pc = 32'h3100; seen = 1'b0;
        repeat (12) cycle();
`ifdef IFU_ALIGN_CHECK_EN
        check("align_exc_delivered", 32'(halted_m), 32'd1);
`else
        check("align_forced_tgt", 32'(seen), 32'd1);
`endif

        // Reset while a request waits, with an ack arriving during reset.
        do_reset(1'b0);
        min_wait = 3; max_wait = 3;
        cycle();
        cycle();
        check("wait_req_held", 32'(cap_req), 32'd1);
        min_wait = 0; max_wait = 0;
        do_reset(1'b1);
        watch_pc = RST_PC; seen = 1'b0;
        repeat (5) cycle();
        check("post_reset_fetch", 32'(seen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
